// File: rtl/cdb_pkg.sv
// cdb_pkg: shared defaults and the reserved "no tag" value for the CDB arbiter
package cdb_pkg;
  localparam int N_REQ_DEF  = 4;
  localparam int TAG_W_DEF  = 3;
  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;
  localparam int TAG_NONE   = 0;
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin one-hot picker starting its search at ptr
module rr_picker #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  // rotating the doubled vector puts requester ptr at bit 0, so the lowest set bit is the winner
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? IW'(k) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    idx = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    any = |req;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter registering one producer result per cycle onto the CDB
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                cdb_valid,
  output logic [TAG_W-1:0]    cdb_tag,
  output logic [DATA_W-1:0]   cdb_data,
  output logic [IW-1:0]       cdb_src,
  output logic                tag_err,
  output logic [CNT_W-1:0]    bcast_count
);
  logic [IW-1:0]    ptr, idx;
  logic [N_REQ-1:0] grant;
  logic             any, go, tag_ok;
  logic [TAG_W-1:0] win_tag;
  rr_picker #(.N(N_REQ)) u_pick (.req(req_valid), .ptr(ptr), .grant(grant), .idx(idx), .any(any));
  assign go        = any & ~flush & ~rst;
  assign req_ready = go ? grant : '0;
  assign win_tag   = req_tag[idx*TAG_W +: TAG_W];
  assign tag_ok    = win_tag != TAG_W'(TAG_NONE);
  // a tag-0 grant is consumed and advances ptr, but only raises tag_err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
      tag_err     <= 1'b0;
      bcast_count <= '0;
    end else begin
      cdb_valid <= go & tag_ok;
      tag_err   <= go & ~tag_ok;
      ptr       <= flush ? '0 : go ? (idx == IW'(N_REQ - 1) ? '0 : idx + 1'b1) : ptr;
      if (go & tag_ok) begin
        cdb_tag     <= win_tag;
        cdb_data    <= req_data[idx*DATA_W +: DATA_W];
        cdb_src     <= idx;
        bcast_count <= bcast_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus checked each cycle against a behavioural CDB model
module tb_cdb_arbiter;
  localparam int N = 4, TW = 3, DW = 4, CW = 8;
  logic clk = 0, rst = 1, flush = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic cdb_valid, tag_err;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [1:0] cdb_src;
  logic [CW-1:0] bcast_count;
  int n_chk = 0, n_fail = 0;

  cdb_arbiter dut (.clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .tag_err(tag_err), .bcast_count(bcast_count));

  always #5 clk = ~clk;

  // model state
  int m_ptr = 0, m_cnt = 0, m_src = 0, m_tag = 0, m_data = 0;
  bit m_valid = 0, m_err = 0;

  function automatic int win_idx();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int tag_of(int i);
    return int'((req_tag >> (i * TW)) & ((1 << TW) - 1));
  endfunction

  function automatic int data_of(int i);
    return int'((req_data >> (i * DW)) & ((1 << DW) - 1));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_src = 0; m_tag = 0; m_data = 0; m_valid = 0; m_err = 0;
    end else begin
      int w;
      w = win_idx();
      m_valid = 0;
      m_err = 0;
      if (flush) m_ptr = 0;
      else if (w >= 0) begin
        m_ptr = (w + 1) % N;
        if (tag_of(w) == 0) m_err = 1;
        else begin
          m_valid = 1; m_tag = tag_of(w); m_data = data_of(w); m_src = w;
          m_cnt = (m_cnt + 1) % (1 << CW);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int w;
    w = win_idx();
    chk("req_ready", 32'(req_ready), (rst || flush || w < 0) ? 0 : 32'(1 << w));
    chk("cdb_valid", 32'(cdb_valid), 32'(m_valid));
    chk("tag_err", 32'(tag_err), 32'(m_err));
    chk("bcast_count", 32'(bcast_count), 32'(m_cnt));
    chk("cdb_tag", 32'(cdb_tag), 32'(m_tag));
    chk("cdb_data", 32'(cdb_data), 32'(m_data));
    chk("cdb_src", 32'(cdb_src), 32'(m_src));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; flush = 0;
    req_tag = {3'd4, 3'd3, 3'd2, 3'd1};
    req_data = {4'd11, 4'd10, 4'd9, 4'd8};
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    // async reset in the middle of activity
    do_reset();
    req_valid = 4'b1111;
    tick(); tick();
    rst = 1;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(cdb_valid), 0);
    chk("rst_count", 32'(bcast_count), 0);
    chk("rst_tag", 32'(cdb_tag), 0);
    chk("rst_src", 32'(cdb_src), 0);
    tick();
    rst = 0;
    at_neg();
    chk("first_grant", 32'(req_ready), 32'h1);
    // single requester
    do_reset();
    req_tag[6 +: 3] = 3'd5; req_data[8 +: 4] = 4'd9;
    req_valid = 4'b0100;
    at_neg();
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    at_neg();
    chk("single_valid", 32'(cdb_valid), 1);
    chk("single_tag", 32'(cdb_tag), 5);
    chk("single_data", 32'(cdb_data), 9);
    chk("single_src", 32'(cdb_src), 2);
    chk("single_count", 32'(bcast_count), 1);
    // fairness
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      at_neg();
      chk("fair_order", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
    end
    req_valid = '0;
    at_neg();
    chk("fair_count", 32'(bcast_count), 8);
    chk("fair_src", 32'(cdb_src), 3);
    // wrap and skip
    do_reset();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0011;
    at_neg();
    chk("wrap_r0", 32'(req_ready), 32'h1);
    tick();
    at_neg();
    chk("wrap_r1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1111;
    at_neg();
    chk("wrap_ptr2", 32'(req_ready), 32'h4);
    // reserved tag
    do_reset();
    req_tag[3 +: 3] = 3'd0;
    req_valid = 4'b0010;
    at_neg();
    chk("tag0_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    at_neg();
    chk("tag0_valid", 32'(cdb_valid), 0);
    chk("tag0_err", 32'(tag_err), 1);
    chk("tag0_count", 32'(bcast_count), 0);
    tick();
    at_neg();
    chk("tag0_err_pulse", 32'(tag_err), 0);
    // flush
    do_reset();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1000; flush = 1;
    at_neg();
    chk("flush_ready", 32'(req_ready), 0);
    chk("flush_keep", 32'(cdb_valid), 1);
    tick();
    flush = 0;
    at_neg();
    chk("flush_valid", 32'(cdb_valid), 0);
    chk("flush_r3", 32'(req_ready), 32'h8);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010; flush = 1;
    tick();
    flush = 0;
    at_neg();
    chk("flush_ptr0", 32'(req_ready), 32'h2);
    tick();
    // counter wrap
    do_reset();
    req_valid = 4'b1111;
    repeat (256) tick();
    req_valid = '0;
    at_neg();
    chk("wrap_count", 32'(bcast_count), 0);
    chk("wrap_valid", 32'(cdb_valid), 1);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) between N result producers, such as functional units and load buffers.
- Grants one producer per cycle using a round-robin policy.
- Registers the winner's tag and data onto cdb_tag/cdb_data for the reservation stations and register file.
- Sits in top between the execution units and the cdb_data broadcast that drives uo_out[3:0].

Parameters:
- N_REQ, 4, number of requesters (2..8)
- TAG_W, 3, producer tag width; tag 0 is reserved as "no tag"
- DATA_W, 4, broadcast data width
- CNT_W, 8, width of the broadcast counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash: no grant this cycle, pointer returns to 0
- req_valid  in  N_REQ  per-requester result valid
- req_tag  in  N_REQ*TAG_W  packed tags, requester i at [i*TAG_W +: TAG_W]
- req_data  in  N_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  combinational one-hot grant
- cdb_valid  out  1  registered broadcast valid
- cdb_tag  out  TAG_W  registered broadcast tag
- cdb_data  out  DATA_W  registered broadcast data
- cdb_src  out  clog2(N_REQ)  index of the requester that produced the current broadcast
- tag_err  out  1  registered pulse: a granted request carried tag 0
- bcast_count  out  CNT_W  number of broadcasts since reset, wraps

Behaviour:
- Reset (rst=1, asynchronous):
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, tag_err=0, bcast_count=0.
  - Round-robin pointer ptr=0.
  - While rst=1, req_ready=0.
- Handshake:
  - A transfer occurs on a cycle where req_valid[i]=1 and req_ready[i]=1.
  - A requester holds valid, tag and data stable until it is granted.
  - req_ready is combinational from req_valid, ptr and flush.
  - At most one bit of req_ready is set.
- Arbitration:
  - Search starts at index ptr and ascends modulo N_REQ; the first requester with req_valid=1 wins.
  - After a grant to index i, ptr <= (i+1) mod N_REQ.
  - With no grant, ptr is unchanged.
  - Wrap-around: ptr=N_REQ-1 searches N_REQ-1, 0, 1, and so on.
- Broadcast timing:
  - Latency is 1 cycle. A grant in cycle t gives cdb_valid=1 in cycle t+1, with the winner's tag, data and index.
  - With no grant, cdb_valid=0 next cycle; cdb_tag, cdb_data and cdb_src hold their last values.
  - The CDB cannot be stalled: a grant is possible every cycle, so back-to-back broadcasts are legal.
- Reserved tag:
  - A granted request with tag 0 is consumed (req_ready=1) but is not broadcast.
  - Next cycle: cdb_valid=0, tag_err=1 for one cycle, bcast_count not incremented, ptr advances as for a normal grant.
- Counter: bcast_count increments by 1 on each cycle with cdb_valid=1 and wraps from 2^CNT_W-1 to 0.
- Flush:
  - flush=1 forces req_ready=0 and ptr<=0.
  - Next cycle: cdb_valid=0 and tag_err=0.
  - A broadcast already registered (currently visible on the CDB) completes its cycle; it is not retracted.
- Reset mid-operation: any pending grant or registered broadcast is dropped immediately.
- Simultaneous flush and rst: rst dominates.

Decomposition:
- cdb_pkg holds TAG_W, DATA_W, N_REQ defaults and the TAG_NONE=0 constant.
- Sub-module rr_picker: a combinational round-robin one-hot picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, encoded index, any_grant.
  - Implemented as a double-width rotate-and-priority-encode.
- cdb_arbiter holds ptr, the output registers, tag_err and the counter.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with req_valid=4'b1111 -> all outputs 0 immediately, req_ready=0; after release the first grant is to requester 0.
- Single requester: req_valid=4'b0100, tag=5, data=9 -> req_ready=4'b0100 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=9, cdb_src=2, bcast_count=1.
- Fairness: all four held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; cdb_valid=1 on 8 consecutive cycles; bcast_count=8.
- Wrap and skip: ptr=3 with req_valid=4'b0011 -> requester 0 granted, then requester 1; ptr ends at 2.
- Reserved tag: requester 1 valid with tag 0 -> granted; next cycle cdb_valid=0, tag_err=1, bcast_count unchanged.
- Flush: flush=1 while req_valid=4'b1000 and ptr=2 -> req_ready=0; next cycle cdb_valid=0 and ptr=0; with flush=0 requester 3 is granted that cycle.
- Counter wrap: 256 broadcasts -> bcast_count returns to 0.
